serial_adder_seq: RTL and testbench
===================================

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8; operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE or DONE.
REQ-005 SHALL have port a_in, input, WIDTH, operand A; captured on the accepted start cycle.
REQ-006 SHALL have port b_in, input, WIDTH, operand B; captured on the accepted start cycle.
REQ-007 SHALL have port busy, output, 1, high while an addition is in progress (ADD state).
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port sum_out, output, WIDTH, result bits (A+B) mod 2^WIDTH.
REQ-010 SHALL have port carry_out, output, 1, carry out of the MSB.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, ADD, DONE.
REQ-012 IDLE: start=1 -> load A/B shift registers, clear carry flop, clear bit counter, go to ADD; start=0 -> stay.
REQ-013 ADD: each cycle, form s = a0 ^ b0 ^ c and c' = (a0&b0) | (c&(a0^b0)), i.e. two cascaded half-add steps on the operand LSBs plus the carry flop.
REQ-014 ADD: each cycle, shift s into the result register at the MSB end, shift both operand registers right by one, update the carry flop with c', and increment the counter.
REQ-015 ADD: after exactly WIDTH bit-cycles, go to DONE; carry_out takes the final c'.
REQ-016 DONE: assert done for exactly that one cycle; busy is 0.
REQ-017 DONE: start=1 is accepted as in IDLE and goes to ADD; otherwise go to IDLE.
REQ-018 Latency SHALL be WIDTH+1 cycles from the accepted start edge to the done-high cycle.
REQ-019 sum_out and carry_out SHALL hold their last result from DONE until the next accepted start.
REQ-020 sum_out and carry_out SHALL be undefined-but-stable (not required valid) during ADD.
REQ-021 start during ADD SHALL be ignored; it SHALL NOT restart, queue or corrupt the operation.
REQ-022 a_in and b_in changes after the accepted start cycle SHALL NOT affect the result.
REQ-023 Wrap-around: the result SHALL be (A+B) mod 2^WIDTH, with the overflow bit only on carry_out.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear busy, done, sum_out, carry_out, the carry flop, the counter and the operand registers, regardless of clk.
REQ-025 Reset mid-ADD SHALL abandon the operation; no done pulse SHALL follow.
REQ-026 After rst_n rises, the first accepted start SHALL be on the first clk edge with start=1.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output port ovf, 1 bit, set in DONE to the signed overflow (carry into MSB XOR carry out of MSB), held with sum_out, and cleared by reset.
REQ-028 Macro SERIAL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour unchanged.

Verification (WIDTH=8)
REQ-029 Test: reset, then start with A=0x0F, B=0x01 -> done on cycle 9 after start, sum_out=0x10, carry_out=0, busy high for cycles 1-8.
REQ-030 Test: A=0xFF, B=0x01 -> sum_out=0x00, carry_out=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-031 Test: A=0x7F, B=0x01 with SERIAL_ADDER_OVF_EN -> sum_out=0x80, carry_out=0, ovf=1.
REQ-032 Test: start with A=0x12, B=0x34, pulse start again at cycle 3 with new operands -> single done at cycle 9, sum_out=0x46.
REQ-033 Test: pull rst_n low at cycle 4 of an addition -> outputs zero immediately, no done pulse; a new start with A=0x01, B=0x02 then gives sum_out=0x03.
REQ-034 Test: start held high through DONE (A=0x10, B=0x20, then 0x01/0x01) -> back-to-back results 0x30 then 0x02, done pulses 9 cycles apart.

Source files
------------

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder, one operand bit per cycle; optional SERIAL_ADDER_OVF_EN adds a signed-overflow output
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             c, s, c_nx, load, last;

    // full add on the operand LSBs, start acceptance and next-state
    always_comb begin
        s         = a_sh[0] ^ b_sh[0] ^ c;
        c_nx      = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
        last      = cnt == CW'(WIDTH - 1);
        load      = start && state != ADD;
        next      = load ? ADD : (state == ADD ? (last ? DONE : ADD) : IDLE);
        busy      = state == ADD;
        done      = state == DONE;
        sum_out   = res;
        carry_out = c;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // operand shifters, result shifter, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= a_in;
            b_sh <= b_in;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {s, res[WIDTH-1:1]};
            c    <= c_nx;
            cnt  <= cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)            ovf <= 1'b0;
        else if (busy && last) ovf <= c ^ c_nx;
`endif
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: scoreboard bench for serial_adder_seq (WIDTH=8), SERIAL_ADDER_OVF_EN aware
module tb_serial_adder_seq;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0, sum_out;
    logic         busy, done, carry_out;
    logic         ovf;
    int           n_cmp = 0, n_bad = 0, cyc = 0;
    logic [W+1:0] sb[$];

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                chk("sum_out", sum_out, e[W-1:0]);
                chk("carry_out", carry_out, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, e[W+1]);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // from cycle n0 after the accepted start, wait for done; check latency and busy span
    task automatic wait_done(input int n0, output int at);
        int n, nb;
        n = n0; nb = n0 - 1;
        while (!done && n <= 20) begin
            if (busy) nb++;
            tick();
            n++;
        end
        at = cyc;
        chk("latency", n, W + 1);
        chk("busy_cycles", nb, W);
        chk("busy_in_done", busy, 0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] s, input logic c, input logic o);
        int at;
        sb.push_back({o, c, s});
        start_op(a, b);
        wait_done(1, at);
        tick();
    endtask

    initial begin
        int t1, t2;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        run(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        run(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        chk("hold_sum", sum_out, 8'h80);
        tick();
        chk("hold_sum_idle", sum_out, 8'h80);
        chk("idle_done_low", done, 0);

        // start pulsed again mid-add must be ignored
        sb.push_back({1'b0, 1'b0, 8'h46});
        start_op(8'h12, 8'h34);
        tick();
        tick();
        a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, t1);
        repeat (12) tick();

        // reset mid-add abandons the operation
        start_op(8'h55, 8'h11);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum_out, 0);
        chk("midrst_carry", carry_out, 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        run(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        // start held through DONE gives back-to-back results
        sb.push_back({1'b0, 1'b0, 8'h30});
        sb.push_back({1'b0, 1'b0, 8'h02});
        a_in = 8'h10; b_in = 8'h20; start = 1'b1;
        tick();
        a_in = 8'h01; b_in = 8'h01;
        wait_done(1, t1);
        tick();
        start = 1'b0;
        wait_done(1, t2);
        chk("done_spacing", t2 - t1, W + 1);
        repeat (4) tick();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
